// File: rtl/ray_lane_collector.sv
// ray_lane_collector
// Issues raster-ordered pixel coordinates round-robin to N_LANES ray lanes.
// Each lane returns results into its own result FIFO. The FIFOs are drained
// in the same lane order, so the output stream comes back in raster order.
// The output carries sof/last_x framing and honours ready_external backpressure.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   image_width, image_height     frame size, sampled when start is accepted
//   start / busy / frame_done     frame control and status
//   issue_valid/lane/x/y          coordinate issue to the lanes
//   issue_ready                   per-lane issue accept
//   res_valid/res_rgb/res_ready   per-lane result input ({r,g,b} per lane)
//   ready_external                downstream accept
//   valid_data_out, r, g, b       output pixel
//   sof, last_x                   frame / row framing of the output pixel
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame; waiting for start
// ST_RUN   | issuing coordinates and collecting results
// ST_DRAIN | every coordinate issued; collecting the remaining results

module ray_lane_collector #(
   parameter  int N_LANES    = 4,
   parameter  int CH_W       = 8,
   parameter  int DIM_W      = 13,
   parameter  int FIFO_DEPTH = 4,
   localparam int LANE_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [DIM_W-1:0]            image_width,
   input  logic [DIM_W-1:0]            image_height,
   input  logic                        start,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        issue_valid,
   output logic [LANE_W-1:0]           issue_lane,
   output logic [DIM_W-1:0]            issue_x,
   output logic [DIM_W-1:0]            issue_y,
   input  logic [N_LANES-1:0]          issue_ready,
   input  logic [N_LANES-1:0]          res_valid,
   input  logic [N_LANES*3*CH_W-1:0]   res_rgb,
   output logic [N_LANES-1:0]          res_ready,
   input  logic                        ready_external,
   output logic                        valid_data_out,
   output logic [CH_W-1:0]             r,
   output logic [CH_W-1:0]             g,
   output logic [CH_W-1:0]             b,
   output logic                        sof,
   output logic                        last_x
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PIX_W = 3 * CH_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t             state_q, state_d;
   logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
   logic [DIM_W-1:0]   ix_q, ix_d, iy_q, iy_d;
   logic [LANE_W-1:0]  ilane_q, ilane_d;
   logic [LANE_W-1:0]  elane_q, elane_d;
   logic [DIM_W-1:0]   ox_q, ox_d, oy_q, oy_d;
   logic               coll_done_q, coll_done_d;
   logic               vld_q, vld_d;
   logic [PIX_W-1:0]   rgb_q, rgb_d;
   logic               sof_q, sof_d;
   logic               lx_q, lx_d;
   logic               last_pix_q, last_pix_d;
   logic               frame_done_q, frame_done_d;

   logic [N_LANES-1:0] fifo_empty;
   logic [N_LANES-1:0] credit_full;
   logic [PIX_W-1:0]   fifo_head [N_LANES];

   logic               issue_fire;
   logic               issue_last;
   logic               pop_en;
   logic               out_accept;

   assign busy        = (state_q != ST_IDLE);
   assign issue_valid = (state_q == ST_RUN) && !credit_full[ilane_q];
   assign issue_fire  = issue_valid && issue_ready[ilane_q];
   assign issue_last  = (ix_q == w_q - DIM_W'(1)) && (iy_q == h_q - DIM_W'(1));
   assign out_accept  = vld_q && ready_external;
   // coll_done_q stops the collector once the frame's last pixel is popped,
   // so stray results left in a FIFO are not emitted as part of this frame.
   assign pop_en      = busy && !coll_done_q && !fifo_empty[elane_q] &&
                        (!vld_q || ready_external);

   // ------------------------------------------------------------------
   // Per-lane result FIFO and issue credit counter
   // ------------------------------------------------------------------
   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      logic [PIX_W-1:0] mem_q [FIFO_DEPTH];
      logic [PIX_W-1:0] mem_d [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] outst_q, outst_d;
      logic             full;
      logic             push;
      logic             pop;
      logic             inc;
      logic             dec;

      assign full           = (cnt_q == CNT_W'(FIFO_DEPTH));
      assign fifo_empty[i]  = (cnt_q == '0);
      assign res_ready[i]   = !full;
      assign push           = res_valid[i] && !full;
      assign pop            = pop_en && (elane_q == LANE_W'(i));
      assign fifo_head[i]   = mem_q[rd_q];
      assign credit_full[i] = (outst_q == CNT_W'(FIFO_DEPTH));
      assign inc            = issue_fire && (ilane_q == LANE_W'(i));
      // Results buffered while idle were never issued; keep the credit at 0.
      assign dec            = pop && (outst_q != '0);

      always_comb begin
         mem_d   = mem_q;
         wr_d    = wr_q;
         rd_d    = rd_q;
         cnt_d   = cnt_q;
         outst_d = outst_q;
         if (push) begin
            mem_d[wr_q] = res_rgb[i*PIX_W +: PIX_W];
            wr_d = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_d = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
         end
         if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
         if (inc && !dec) begin
            outst_d = outst_q + CNT_W'(1);
         end else if (dec && !inc) begin
            outst_d = outst_q - CNT_W'(1);
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
               mem_q[k] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            outst_q <= '0;
         end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sequencing, issue counters, collection and output register
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      w_d          = w_q;
      h_d          = h_q;
      ix_d         = ix_q;
      iy_d         = iy_q;
      ilane_d      = ilane_q;
      elane_d      = elane_q;
      ox_d         = ox_q;
      oy_d         = oy_q;
      coll_done_d  = coll_done_q;
      vld_d        = vld_q;
      rgb_d        = rgb_q;
      sof_d        = sof_q;
      lx_d         = lx_q;
      last_pix_d   = last_pix_q;
      frame_done_d = 1'b0;

      if (issue_fire) begin
         ilane_d = (ilane_q == LANE_W'(N_LANES - 1)) ? '0 : ilane_q + LANE_W'(1);
         if (ix_q == w_q - DIM_W'(1)) begin
            ix_d = '0;
            iy_d = iy_q + DIM_W'(1);
         end else begin
            ix_d = ix_q + DIM_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((image_width != '0) && (image_height != '0)) begin
                  state_d     = ST_RUN;
                  w_d         = image_width;
                  h_d         = image_height;
                  ix_d        = '0;
                  iy_d        = '0;
                  ilane_d     = '0;
                  elane_d     = '0;
                  ox_d        = '0;
                  oy_d        = '0;
                  coll_done_d = 1'b0;
                  last_pix_d  = 1'b0;
               end else begin
                  frame_done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (issue_fire && issue_last) begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
         end
      endcase

      if (out_accept) begin
         vld_d = 1'b0;
         if (last_pix_q) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
         end
      end

      if (pop_en) begin
         vld_d      = 1'b1;
         rgb_d      = fifo_head[elane_q];
         sof_d      = (ox_q == '0) && (oy_q == '0);
         lx_d       = (ox_q == w_q - DIM_W'(1));
         last_pix_d = (ox_q == w_q - DIM_W'(1)) && (oy_q == h_q - DIM_W'(1));
         elane_d    = (elane_q == LANE_W'(N_LANES - 1)) ? '0 : elane_q + LANE_W'(1);
         if (ox_q == w_q - DIM_W'(1)) begin
            ox_d = '0;
            oy_d = oy_q + DIM_W'(1);
            if (oy_q == h_q - DIM_W'(1)) begin
               coll_done_d = 1'b1;
            end
         end else begin
            ox_d = ox_q + DIM_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         w_q          <= '0;
         h_q          <= '0;
         ix_q         <= '0;
         iy_q         <= '0;
         ilane_q      <= '0;
         elane_q      <= '0;
         ox_q         <= '0;
         oy_q         <= '0;
         coll_done_q  <= 1'b0;
         vld_q        <= 1'b0;
         rgb_q        <= '0;
         sof_q        <= 1'b0;
         lx_q         <= 1'b0;
         last_pix_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         w_q          <= w_d;
         h_q          <= h_d;
         ix_q         <= ix_d;
         iy_q         <= iy_d;
         ilane_q      <= ilane_d;
         elane_q      <= elane_d;
         ox_q         <= ox_d;
         oy_q         <= oy_d;
         coll_done_q  <= coll_done_d;
         vld_q        <= vld_d;
         rgb_q        <= rgb_d;
         sof_q        <= sof_d;
         lx_q         <= lx_d;
         last_pix_q   <= last_pix_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign frame_done     = frame_done_q;
   assign issue_lane     = ilane_q;
   assign issue_x        = ix_q;
   assign issue_y        = iy_q;
   assign valid_data_out = vld_q;
   assign r              = rgb_q[PIX_W-1 -: CH_W];
   assign g              = rgb_q[2*CH_W-1 -: CH_W];
   assign b              = rgb_q[CH_W-1:0];
   assign sof            = sof_q;
   assign last_x         = lx_q;

endmodule

// File: tb/tb_ray_lane_collector.sv
// Testbench for ray_lane_collector with four lanes. Bench-side lane models
// return a colour derived from each issued coordinate after a per-lane
// latency. The expected pixel for each issue is queued, in raster order, from
// the bench's own coordinate counter, then popped and compared as the DUT
// emits pixels.
module tb_ray_lane_collector;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int DW = 13;
   localparam int PW = 3 * CW;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [DW-1:0]     image_width = '0;
   logic [DW-1:0]     image_height = '0;
   logic              start = 1'b0;
   logic              busy;
   logic              frame_done;
   logic              issue_valid;
   logic [1:0]        issue_lane;
   logic [DW-1:0]     issue_x;
   logic [DW-1:0]     issue_y;
   logic [N-1:0]      issue_ready = '1;
   logic [N-1:0]      res_valid = '0;
   logic [N*PW-1:0]   res_rgb = '0;
   logic [N-1:0]      res_ready;
   logic              ready_external = 1'b1;
   logic              valid_data_out;
   logic [CW-1:0]     r, g, b;
   logic              sof;
   logic              last_x;

   always #5 clk = ~clk;

   ray_lane_collector #(.N_LANES(N), .CH_W(CW), .DIM_W(DW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .image_width(image_width), .image_height(image_height),
      .start(start), .busy(busy), .frame_done(frame_done),
      .issue_valid(issue_valid), .issue_lane(issue_lane),
      .issue_x(issue_x), .issue_y(issue_y), .issue_ready(issue_ready),
      .res_valid(res_valid), .res_rgb(res_rgb), .res_ready(res_ready),
      .ready_external(ready_external), .valid_data_out(valid_data_out),
      .r(r), .g(g), .b(b), .sof(sof), .last_x(last_x)
   );

   typedef struct {
      logic [PW-1:0] rgb;
      logic          sof;
      logic          lx;
   } exp_t;

   typedef struct {
      int            lane;
      logic [PW-1:0] rgb;
      int            t;
   } pend_t;

   exp_t  sb[$];
   pend_t pend[$];
   int    lat [N];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] color(input int x, input int y);
      logic [7:0] cr, cg, cb;
      cr = 8'(x * 7 + 1);
      cg = 8'(y * 13 + 3);
      cb = 8'(x + y * 5) ^ 8'hA5;
      return {cr, cg, cb};
   endfunction

   // Runs one frame from start to frame_done. tog toggles ready_external;
   // lane 1 withholds results while c < stall_until; abort_at >= 0 returns
   // early at that cycle so the caller can apply reset mid-frame.
   task automatic run_frame(input int w, input int h, input bit tog,
                            input int stall_until, input int abort_at);
      int ix, iy, total, issued, accepted, done_at, idx, c_end;
      bit held, finished, exp_done, rdy;
      logic [PW-1:0] h_rgb;
      logic h_sof, h_lx;
      exp_t e, ne;
      pend_t p;
      ix = 0; iy = 0; total = w * h; issued = 0; accepted = 0;
      done_at = -1; held = 0; finished = 0; c_end = 0;
      h_rgb = '0; h_sof = 0; h_lx = 0;
      @(negedge clk);
      image_width = DW'(w); image_height = DW'(h); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (c > 0) @(negedge clk);
         if (abort_at >= 0 && c == abort_at) return;
         if (c == 0) begin
            chk("start_issue_valid", issue_valid, 1);
            chk("start_busy", busy, 1);
         end
         // start while busy must be ignored
         if (tog && c == 5) begin
            start = 1'b1; image_width = 2; image_height = 1;
         end else begin
            start = 1'b0;
         end
         exp_done = (c == done_at);
         if (frame_done || exp_done) chk("frame_done", frame_done, exp_done);
         if (exp_done) chk("busy_at_done", busy, 0);
         if (valid_data_out) begin
            if (held) begin
               chk("hold_rgb", {r, g, b}, h_rgb);
               chk("hold_sof", sof, h_sof);
               chk("hold_last_x", last_x, h_lx);
            end else if (sb.size() == 0) begin
               chk("extra_pixel", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("pix_rgb", {r, g, b}, e.rgb);
               chk("pix_sof", sof, e.sof);
               chk("pix_last_x", last_x, e.lx);
               h_rgb = {r, g, b}; h_sof = sof; h_lx = last_x;
            end
         end
         rdy = tog ? (c % 2 == 0) : 1'b1;
         ready_external = rdy;
         if (valid_data_out && rdy) begin
            accepted++;
            held = 0;
            if (accepted == total) done_at = c + 1;
         end else begin
            held = valid_data_out;
         end
         // lane models
         res_valid = '0;
         for (int i = 0; i < N; i++) begin
            idx = -1;
            for (int k = 0; k < pend.size(); k++) begin
               if (pend[k].lane == i) begin
                  idx = k;
                  break;
               end
            end
            if (idx >= 0 && pend[idx].t <= c && !(i == 1 && c < stall_until)) begin
               res_valid[i] = 1'b1;
               res_rgb[i*PW +: PW] = pend[idx].rgb;
               if (res_ready[i]) pend.delete(idx);
            end
         end
         if (stall_until > 0 && c == stall_until - 1) begin
            chk("stall_issue_valid", issue_valid, 0);
            chk("stall_issue_lane", issue_lane, 1);
            chk("stall_issued", issued, 17);
         end
         // issue handshake
         if (issue_valid && issue_ready[issue_lane]) begin
            if (issued >= total) begin
               chk("issue_after_last", 1, 0);
            end else begin
               chk("issue_x", issue_x, ix);
               chk("issue_y", issue_y, iy);
               chk("issue_lane", issue_lane, issued % N);
               p.lane = int'(issue_lane);
               p.rgb  = color(int'(issue_x), int'(issue_y));
               p.t    = c + lat[issue_lane];
               pend.push_back(p);
               ne.rgb = color(ix, iy);
               ne.sof = (ix == 0 && iy == 0);
               ne.lx  = (ix == w - 1);
               sb.push_back(ne);
               issued++;
               if (ix == w - 1) begin
                  ix = 0;
                  iy++;
               end else begin
                  ix++;
               end
            end
         end
         if (done_at >= 0 && c > done_at) begin
            finished = 1;
            c_end = c;
            break;
         end
      end
      chk("frame_complete", finished, 1);
      chk("sb_empty", sb.size(), 0);
      chk("lanes_drained", pend.size(), 0);
      if (tog) chk("toggle_cycles_bound", (c_end <= 2 * total + 10), 1);
      res_valid = '0;
      ready_external = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_valid_out", valid_data_out, 0);
      chk("rst_res_ready", res_ready, 4'hF);
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_issue_xyl", {issue_x, issue_y, issue_lane}, 0);
      chk("rst_framing", {sof, last_x, frame_done}, 0);
      reset_n = 1'b1;

      lat = '{3, 3, 3, 3};
      run_frame(4, 2, 0, 0, -1);
      lat = '{2, 2, 2, 2};
      run_frame(3, 2, 0, 0, -1);
      lat = '{1, 7, 2, 5};
      run_frame(6, 4, 0, 0, -1);
      run_frame(6, 4, 0, 40, -1);
      lat = '{2, 2, 2, 2};
      run_frame(4, 3, 1, 0, -1);

      // zero-dimension start
      @(negedge clk);
      image_width = 0; image_height = 5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_frame_done", frame_done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_issue_valid", issue_valid, 0);
      @(negedge clk);
      chk("zero_frame_done_pulse", frame_done, 0);
      chk("zero_busy_after", busy, 0);

      // reset mid-frame, then a clean frame
      lat = '{3, 3, 3, 3};
      run_frame(4, 2, 0, 0, 6);
      chk("pre_reset_valid", valid_data_out, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", valid_data_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_issue_valid", issue_valid, 0);
      chk("mid_rst_rgb", {r, g, b}, 0);
      chk("mid_rst_framing", {sof, last_x, frame_done}, 0);
      chk("mid_rst_res_ready", res_ready, 4'hF);
      res_valid = '0;
      pend.delete();
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      run_frame(4, 2, 0, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
